// File: rtl/bus_datapath.sv
// rtl/bus_datapath.sv - single-bus datapath with register file, clear sweep and req/ack memory port
module bus_datapath #(
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 16,
    parameter int REG_COUNT = 64,
    parameter int RSEL_W    = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        src_sel,
    input  logic [6:0]        dst_en,
    input  logic              z_load,
    input  logic              pc_inc,
    input  logic [RSEL_W-1:0] reg_rsel,
    input  logic [RSEL_W-1:0] reg_wsel,
    input  logic              reg_clear,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [WIDTH-1:0]  alu_z,
    output logic [WIDTH-1:0]  alu_x,
    output logic [WIDTH-1:0]  alu_y,
    output logic [WIDTH-1:0]  ir,
    output logic [WIDTH-1:0]  bus,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              clearing,
    output logic              err
);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} mem_state_e;

    logic [WIDTH-1:0]  pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [WIDTH-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic [WIDTH-1:0]  regs_q [REG_COUNT];
    mem_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic              err_q, err_d, clearing_q, clearing_d;
    logic [RSEL_W-1:0] clr_idx_q, clr_idx_d;

    logic              reg_we;
    logic [RSEL_W-1:0] reg_widx;
    logic [WIDTH-1:0]  reg_wdata;
    logic [WIDTH-1:0]  bus_w;
    logic              src_bad;
    logic              is_busy;

    always_comb begin
        bus_w   = '0;
        src_bad = 1'b0;
        case (src_sel)
            4'd0:    bus_w = '0;
            4'd1:    bus_w = pc_q;
            4'd2:    bus_w = ir_q;
            4'd3:    bus_w = mar_q;
            4'd4:    bus_w = mdr_q;
            4'd5:    bus_w = x_q;
            4'd6:    bus_w = y_q;
            4'd7:    bus_w = z_q;
            4'd8:    bus_w = regs_q[reg_rsel];
            default: src_bad = 1'b1;
        endcase
    end

    always_comb begin
        is_busy = (state_q != ST_IDLE);

        pc_d = pc_q;
        if (dst_en[0]) begin
            pc_d = bus_w;
        end else if (pc_inc) begin
            pc_d = pc_q + WIDTH'(1);
        end
        ir_d  = dst_en[1] ? bus_w : ir_q;
        // MAR/MDR must stay stable while a transaction is on the port
        mar_d = (dst_en[2] && !is_busy) ? bus_w : mar_q;
        mdr_d = mdr_q;
        if (state_q == ST_RD && mem_ack) begin
            mdr_d = mem_rdata;
        end else if (dst_en[3] && !is_busy) begin
            mdr_d = bus_w;
        end
        x_d = dst_en[4] ? bus_w : x_q;
        y_d = dst_en[5] ? bus_w : y_q;
        z_d = z_load ? alu_z : z_q;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_rd) begin
                    state_d = ST_RD;
                end else if (mem_wr) begin
                    state_d = ST_WR;
                end
            end
            ST_RD, ST_WR: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        mem_req_d = (state_d != ST_IDLE);
        mem_we_d  = (state_d == ST_WR);

        reg_we    = 1'b0;
        reg_widx  = reg_wsel;
        reg_wdata = bus_w;
        if (clearing_q) begin
            reg_we    = 1'b1;
            reg_widx  = clr_idx_q;
            reg_wdata = '0;
        end else if (dst_en[6]) begin
            reg_we = 1'b1;
        end

        clearing_d = clearing_q;
        clr_idx_d  = clr_idx_q;
        if (clearing_q) begin
            clr_idx_d = clr_idx_q + RSEL_W'(1);
            if (clr_idx_q == RSEL_W'(REG_COUNT - 1)) begin
                clearing_d = 1'b0;
            end
        end
        if (reg_clear) begin
            clearing_d = 1'b1;
            clr_idx_d  = '0;
        end

        err_d = err_q | src_bad
              | (is_busy & (dst_en[2] | dst_en[3] | mem_rd | mem_wr))
              | (clearing_q & dst_en[6])
              | (!is_busy & mem_rd & mem_wr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            ir_q       <= '0;
            mar_q      <= '0;
            mdr_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            err_q      <= 1'b0;
            clearing_q <= 1'b1;
            clr_idx_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            err_q      <= err_d;
            clearing_q <= clearing_d;
            clr_idx_q  <= clr_idx_d;
        end
    end

    // The sweep itself zeroes the array, so the storage needs no reset
    always_ff @(posedge clk) begin
        if (!reset && reg_we) begin
            regs_q[reg_widx] <= reg_wdata;
        end
    end

    assign alu_x     = x_q;
    assign alu_y     = y_q;
    assign ir        = ir_q;
    assign bus       = bus_w;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mar_q[ADDR_W-1:0];
    assign mem_wdata = mdr_q;
    assign busy      = (state_q != ST_IDLE);
    assign clearing  = clearing_q;
    assign err       = err_q;

endmodule
